cardinal_nic_fifo: RTL and testbench
====================================

# cardinal_nic_fifo

Parametrised successor to the single-entry cardinal network interface controller. It sits between one processor core's NIC port (2-bit register address, enable, write-enable, data in/out) and one ring-router local port (send/ready/data handshakes plus ring polarity). Its receive and transmit channels are DEPTH-entry FIFOs instead of single buffers, it exposes occupancy and a drop counter, and it injects only in the ring phase that matches each packet's virtual channel.

## Interface
- DATA_WIDTH, 64: packet/data width; bit 0 is MSB, `[0:DATA_WIDTH-1]` ordering.
- DEPTH, 4: entries per FIFO; power of two, >= 2.
- VC_BIT, 1: index of the packet's virtual-channel bit.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  2  register select: 00 rx data, 01 rx status, 10 tx data, 11 tx status.
- d_in  input  DATA_WIDTH  write data from core.
- d_out  output  DATA_WIDTH  registered read data to core.
- nicEn  input  1  register access enable.
- nicEnWr  input  1  1 = write, 0 = read; only meaningful with nicEn.
- net_si  input  1  router delivers a packet this cycle.
- net_ri  output  1  NIC can accept a packet (rx FIFO not full).
- net_di  input  DATA_WIDTH  packet from router.
- net_so  output  1  NIC injects a packet this cycle.
- net_ro  input  1  router can accept an injected packet.
- net_do  output  DATA_WIDTH  packet to router (tx FIFO head).
- net_polarity  input  1  current ring phase.

## Operation
- Two FIFOs (rx, tx), each with a DEPTH-entry array, read/write pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count (0..DEPTH).
- Rx push: net_si && net_ri writes net_di at the tail. net_si while net_ri=0 is ignored; no state change.
- Rx pop: nicEn && !nicEnWr && addr=00 && rx count>0. Head is loaded into d_out, pointer advances. If rx is empty, d_out loads 0 and nothing pops.
- Read addr 01: d_out = rx count, zero-extended.
- Read addr 11: d_out = (drop_cnt << 16) | tx count.
- Read addr 10: d_out = 0.
- Tx push: nicEn && nicEnWr && addr=10. Fullness is judged on the count at the start of the cycle.
  - Not full: d_in is appended.
  - Full: write is dropped and the 8-bit drop_cnt increments, saturating at 255. This applies even if an injection frees a slot in the same cycle.
- Write addr 11 clears drop_cnt. Writes to 00/01 are ignored.
- Injection: net_so = (tx count>0) && net_ro && (head[VC_BIT] != net_polarity). net_do = tx head at all times (don't-care when empty). When net_so=1, head pops on that edge.
- A read with nicEn=0 leaves d_out holding its last value.
- Same-cycle push and pop on one FIFO: both happen, count unchanged. Pointers move independently.
- Reset mid-operation discards all FIFO contents immediately.

## Timing
- Reset values: d_out=0, net_ri=1, net_so=0, net_do=0, all counts/pointers/drop_cnt=0.
- d_out latency 1 cycle: the value appears after the edge that samples the read.
- net_ri is a function of registered rx count only. It falls the cycle after the DEPTH-th push and rises the cycle after a pop from a full FIFO.
- net_so/net_do are combinational from registered tx state plus net_ro and net_polarity. Minimum injection latency is 1 cycle after the tx write edge, in a phase where head VC != polarity.
- Sustained throughput: one rx packet per cycle and one tx packet per matching-phase cycle.
- Status reads reflect counts before any push/pop in the same cycle.

## Test plan
- Reset: hold reset=0 mid-traffic, then release. Required: d_out=0, net_ri=1, net_so=0, addr 01 read returns 0, addr 11 read returns 0.
- Rx fill/drain, DEPTH=4:
  - Push 0xA0..0xA3 on consecutive cycles. Required: net_ri=0 the cycle after the 4th push; a 5th net_si is ignored.
  - Four addr-00 reads. Required: return 0xA0..0xA3 in order, one cycle late. A 5th read returns 0.
- Tx phase gating, VC_BIT=1, net_ro=1:
  - Write a packet with bit1=1. Required: net_so=1 only in cycles where net_polarity=0.
  - Packet with bit1=0. Required: injects only when net_polarity=1.
- Tx overflow: net_ro=0, six tx writes. Required: addr-11 read = (2<<16)|4. Write addr 11, then read. Required: 4.
- Simultaneous events:
  - Rx full, addr-00 read and net_si in the same cycle. Required: net_si ignored because net_ri=0.
  - Rx at 3, pop and push in the same cycle. Required: count stays 3, FIFO order preserved.
  - Tx full with write plus injection in the same cycle. Required: write dropped, count 3, drop_cnt 1.
- Pointer wrap: ten push/pop pairs interleaved through rx. Required: data returned in order across the modulo-4 wrap, count never exceeds 4.

Source files
------------

// File: rtl/cardinal_nic_fifo.sv
// Core-to-ring NIC with DEPTH-entry rx/tx FIFOs, occupancy/drop status registers,
// and virtual-channel phase-gated injection onto the ring.
module cardinal_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int VC_BIT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [0:DATA_WIDTH-1] r_rx_mem [DEPTH];
  logic [0:DATA_WIDTH-1] r_tx_mem [DEPTH];
  logic [PTR_W-1:0]      r_rx_wr_ptr, r_rx_rd_ptr, r_tx_wr_ptr, r_tx_rd_ptr;
  logic [CNT_W-1:0]      r_rx_cnt, r_tx_cnt;
  logic [7:0]            r_drop_cnt;
  logic [0:DATA_WIDTH-1] r_d_out;

  logic                  w_rd_access, w_wr_access;
  logic                  w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic                  w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic                  w_tx_wr, w_tx_drop, w_drop_clr;
  logic [0:DATA_WIDTH-1] w_tx_head;
  logic [0:DATA_WIDTH-1] w_rd_data;

  assign w_rd_access = nicEn & ~nicEnWr;
  assign w_wr_access = nicEn & nicEnWr;

  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);

  // Handshakes: a transfer happens on a rising edge where both sides assert
  // (net_si & net_ri for receive, net_so & net_ro for inject); neither side waits on the other.
  assign net_ri    = ~w_rx_full;
  assign w_rx_push = net_si & net_ri;
  assign w_rx_pop  = w_rd_access & (addr == 2'b00) & ~w_rx_empty;

  assign w_tx_head  = r_tx_mem[r_tx_rd_ptr];
  assign net_so     = ~w_tx_empty & net_ro & (w_tx_head[VC_BIT] != net_polarity);
  assign net_do     = w_tx_empty ? '0 : w_tx_head;
  assign w_tx_pop   = net_so;
  assign w_tx_wr    = w_wr_access & (addr == 2'b10);
  assign w_tx_push  = w_tx_wr & ~w_tx_full;
  assign w_tx_drop  = w_tx_wr & w_tx_full;
  assign w_drop_clr = w_wr_access & (addr == 2'b11);

  always_comb begin
    w_rd_data = '0;
    case (addr)
      2'b00:   w_rd_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
      2'b01:   w_rd_data = DATA_WIDTH'(r_rx_cnt);
      2'b11:   w_rd_data = (DATA_WIDTH'(r_drop_cnt) << 16) | DATA_WIDTH'(r_tx_cnt);
      default: w_rd_data = '0;
    endcase
  end

  // Storage arrays are not reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= net_di;
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_cnt    <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_W'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_W'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_W'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_cnt    <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_W'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_W'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_W'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // Overflow is judged on the start-of-cycle count, so a same-cycle injection does not rescue a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_tx_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (w_rd_access) begin
      r_d_out <= w_rd_data;
    end
  end

  assign d_out = r_d_out;

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed self-checking bench for cardinal_nic_fifo with default parameters
// (DATA_WIDTH=64, DEPTH=4, VC_BIT=1).
module tb_cardinal_nic_fifo;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicEnWr;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_checks = 0;
  int n_errors = 0;

  cardinal_nic_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 2 time units after a rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rx_push(input logic [63:0] data);
    net_si = 1'b1;
    net_di = data;
    tick();
    net_si = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [63:0] data);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = data;
    tick();
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    tick();
    nicEn = 1'b0;
  endtask

  logic [0:63] p1, p2;

  initial begin
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    p1 = 64'h4000_0000_0000_00A5;   // index 1 (second MSB) set
    p2 = 64'h0000_0000_0000_00B6;   // index 1 clear

    // Reset state
    repeat (3) tick();
    chk("reset_d_out", d_out, 64'h0);
    chk("reset_net_ri", net_ri, 1);
    chk("reset_net_so", net_so, 0);
    chk("reset_net_do", net_do, 64'h0);
    reset = 1'b1;
    tick();

    // Reset mid-traffic
    rx_push(64'h11);
    rx_push(64'h12);
    reg_wr(2'b10, 64'h22);
    net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    chk("pre_reset_net_so", net_so, 1);
    reset = 1'b0;
    #1;
    chk("midrst_net_so", net_so, 0);
    chk("midrst_net_ri", net_ri, 1);
    chk("midrst_net_do", net_do, 64'h0);
    tick();
    net_ro = 1'b0; net_polarity = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_d_out", d_out, 64'h0);
    reg_rd(2'b01);
    chk("midrst_rx_status", d_out, 64'h0);
    reg_rd(2'b11);
    chk("midrst_tx_status", d_out, 64'h0);

    // Rx fill
    rx_push(64'hA0);
    rx_push(64'hA1);
    rx_push(64'hA2);
    chk("rx_ri_at3", net_ri, 1);
    rx_push(64'hA3);
    chk("rx_ri_full", net_ri, 0);
    rx_push(64'hA4);
    reg_rd(2'b01);
    chk("rx_status_full", d_out, 64'h4);

    // Rx drain
    reg_rd(2'b00);
    chk("rx_rd0", d_out, 64'hA0);
    chk("rx_ri_after_pop", net_ri, 1);
    reg_rd(2'b00);
    chk("rx_rd1", d_out, 64'hA1);
    reg_rd(2'b00);
    chk("rx_rd2", d_out, 64'hA2);
    reg_rd(2'b00);
    chk("rx_rd3", d_out, 64'hA3);
    reg_rd(2'b00);
    chk("rx_rd_empty", d_out, 64'h0);

    // d_out holds without nicEn; addr 10 reads zero
    reg_rd(2'b01);
    chk("rx_status_empty_sel", d_out, 64'h0);
    rx_push(64'h77);
    reg_rd(2'b01);
    chk("rx_status_one", d_out, 64'h1);
    tick();
    chk("d_out_hold", d_out, 64'h1);
    reg_rd(2'b10);
    chk("rd_addr10", d_out, 64'h0);
    reg_rd(2'b00);
    chk("rx_rd_77", d_out, 64'h77);

    // Tx phase gating, packet with VC bit 1
    net_ro = 1'b1; net_polarity = 1'b1;
    reg_wr(2'b10, p1);
    #1;
    chk("p1_so_pol1", net_so, 0);
    chk("p1_net_do", net_do, p1);
    tick();
    #1;
    chk("p1_so_pol1_hold", net_so, 0);
    net_polarity = 1'b0;
    #1;
    chk("p1_so_pol0", net_so, 1);
    tick();
    #1;
    chk("p1_so_after", net_so, 0);
    reg_rd(2'b11);
    chk("p1_tx_empty", d_out, 64'h0);

    // Packet with VC bit 0
    net_polarity = 1'b0;
    reg_wr(2'b10, p2);
    #1;
    chk("p2_so_pol0", net_so, 0);
    tick();
    #1;
    chk("p2_so_pol0_hold", net_so, 0);
    net_polarity = 1'b1;
    #1;
    chk("p2_so_pol1", net_so, 1);
    chk("p2_net_do", net_do, p2);
    tick();
    #1;
    chk("p2_so_after", net_so, 0);

    // Tx overflow
    net_ro = 1'b0;
    for (int i = 0; i < 6; i++) reg_wr(2'b10, 64'h100 + 64'(i));
    reg_rd(2'b11);
    chk("tx_ovf_status", d_out, (64'h2 << 16) | 64'h4);
    chk("tx_ovf_head", net_do, 64'h100);
    reg_wr(2'b11, 64'h0);
    reg_rd(2'b11);
    chk("tx_drop_clr", d_out, 64'h4);

    // Tx full: write plus injection in one cycle
    net_ro = 1'b1; net_polarity = 1'b1;
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h1FF;
    #1;
    chk("txfull_so", net_so, 1);
    tick();
    nicEn = 1'b0; nicEnWr = 1'b0;
    net_ro = 1'b0;
    reg_rd(2'b11);
    chk("txfull_status", d_out, (64'h1 << 16) | 64'h3);
    chk("txfull_head", net_do, 64'h101);
    net_ro = 1'b1;
    tick();
    chk("tx_drain_102", net_do, 64'h102);
    tick();
    chk("tx_drain_103", net_do, 64'h103);
    tick();
    #1;
    chk("tx_drain_so", net_so, 0);
    chk("tx_drain_do", net_do, 64'h0);
    net_ro = 1'b0;
    reg_wr(2'b11, 64'h0);

    // Rx full: read and net_si in the same cycle
    rx_push(64'hB0);
    rx_push(64'hB1);
    rx_push(64'hB2);
    rx_push(64'hB3);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b00;
    net_si = 1'b1; net_di = 64'hBF;
    tick();
    net_si = 1'b0; nicEn = 1'b0;
    chk("rxfull_rd", d_out, 64'hB0);
    reg_rd(2'b01);
    chk("rxfull_cnt", d_out, 64'h3);

    // Rx at 3: pop and push in the same cycle
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b00;
    net_si = 1'b1; net_di = 64'hB4;
    tick();
    net_si = 1'b0; nicEn = 1'b0;
    chk("rx3_rd", d_out, 64'hB1);
    reg_rd(2'b01);
    chk("rx3_cnt", d_out, 64'h3);
    reg_rd(2'b00);
    chk("rx3_b2", d_out, 64'hB2);
    reg_rd(2'b00);
    chk("rx3_b3", d_out, 64'hB3);
    reg_rd(2'b00);
    chk("rx3_b4", d_out, 64'hB4);
    reg_rd(2'b01);
    chk("rx3_empty", d_out, 64'h0);

    // Pointer wrap: ten pushes, ten pops, overlapped
    rx_push(64'hC0);
    for (int i = 1; i < 10; i++) begin
      nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b00;
      net_si = 1'b1; net_di = 64'hC0 + 64'(i);
      tick();
      net_si = 1'b0; nicEn = 1'b0;
      chk($sformatf("wrap_rd%0d", i - 1), d_out, 64'hC0 + 64'(i - 1));
      chk($sformatf("wrap_ri%0d", i - 1), net_ri, 1);
    end
    reg_rd(2'b01);
    chk("wrap_cnt", d_out, 64'h1);
    reg_rd(2'b00);
    chk("wrap_rd9", d_out, 64'hC9);
    reg_rd(2'b00);
    chk("wrap_empty", d_out, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
